// File: rtl/snake_grid_renderer.sv
// snake_grid_renderer
//   Pixel renderer for the grid snake game, placed between the game FSM and VGA timing.
//   Snake/food state is snapshotted once per frame so a frame never tears. For each cell row
//   an FSM walks the segment list during the horizontal blank and builds a per-column bitmap
//   (head/body/food) into the back half of a double buffer. The pixel path then only indexes
//   the front bitmap with a column counter, so no per-segment comparators sit on the pixel path.
//
// Ports
//   Clk            pixel clock, hCount advances by one per Clk
//   Reset          synchronous, active-high
//   Bright         display-active qualifier
//   hCount/vCount  raster position
//   Qi/Qw/Ql/Qc    game state one-hots (initial, win, lose, collect)
//   Food           food location (row*GRID_W + col)
//   Length         snake segment count, saturated to MAX_LEN on capture
//   Locations_Flat segment i at [(MAX_LEN-i)*LOC_W-1 -: LOC_W], i=0 is the head
//   rgb            registered pixel colour, one Clk after hCount/Bright
//   background     registered state colour
//   scan_overrun   sticky flag: a row scan was still running at the first visible pixel
module snake_grid_renderer #(
    parameter int unsigned GRID_W   = 16,
    parameter int unsigned GRID_H   = 16,
    parameter int unsigned CELL     = 30,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned LOC_W    = 8,
    parameter int unsigned X0       = 144,
    parameter int unsigned Y0       = 35,
    parameter int unsigned SCAN_H   = 0,
    parameter logic [11:0] HEAD_RGB = 12'hFF0,
    parameter logic [11:0] BODY_RGB = 12'hCC0,
    parameter logic [11:0] FOOD_RGB = 12'hFFF
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            Bright,
    input  logic [9:0]                      hCount,
    input  logic [9:0]                      vCount,
    input  logic                            Qi,
    input  logic                            Qw,
    input  logic                            Ql,
    input  logic                            Qc,
    input  logic [LOC_W-1:0]                Food,
    input  logic [$clog2(MAX_LEN+1)-1:0]    Length,
    input  logic [MAX_LEN*LOC_W-1:0]        Locations_Flat,
    output logic [11:0]                     rgb,
    output logic [11:0]                     background,
    output logic                            scan_overrun
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned ROW_W  = $clog2(GRID_H + 1);
    localparam int unsigned COL_W  = $clog2(GRID_W + 1);
    localparam int unsigned CIDX_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned SUB_W  = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int unsigned NCELL  = GRID_W * GRID_H;

    // The whole scan (clear + MAX_LEN segments + food) must fit before the first visible pixel.
    if (int'(MAX_LEN) + 2 > int'(X0) - int'(SCAN_H)) begin : gen_scan_budget_check
        $error("snake_grid_renderer: MAX_LEN+2 exceeds X0-SCAN_H scan window");
    end

    // ------------------------------------------------------------------------------------------
    // Per-frame snapshot
    // ------------------------------------------------------------------------------------------
    logic                   frame_start;
    logic [LEN_W-1:0]       len_sat;
    logic [LOC_W-1:0]       locs_q [MAX_LEN];
    logic [LEN_W-1:0]       len_q;
    logic [LOC_W-1:0]       food_q;
    logic                   food_vld_q;

    assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
    assign len_sat     = (Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : Length;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            len_q      <= '0;
            food_q     <= '0;
            food_vld_q <= 1'b0;
        end else if (frame_start) begin
            len_q      <= len_sat;
            food_vld_q <= Qc;
            // Without Qc the previous food location is kept.
            if (Qc) begin
                food_q <= Food;
            end
        end
    end

    // Location storage needs no reset: it is only read below len_q, which is reset.
    always_ff @(posedge Clk) begin
        if (!Reset && frame_start) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                locs_q[i] <= Locations_Flat[(int'(MAX_LEN) - 1 - i) * int'(LOC_W) +: LOC_W];
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Cell row tracking. row_d/sub_d are the values that apply to the current line.
    // ------------------------------------------------------------------------------------------
    logic [ROW_W-1:0] row_q, row_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             swap;
    logic             row0_line;
    logic             start_line;
    logic             scan_start;
    logic [ROW_W-1:0] tgt_next;

    always_comb begin
        row_d = row_q;
        sub_d = sub_q;
        swap  = 1'b0;
        if (hCount == 10'd0) begin
            if (vCount == 10'(Y0)) begin
                row_d = '0;
                sub_d = '0;
                swap  = 1'b1;
            end else if (row_q < ROW_W'(GRID_H)) begin
                if (sub_q == SUB_W'(CELL - 1)) begin
                    sub_d = '0;
                    row_d = row_q + ROW_W'(1);
                    swap  = 1'b1;
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            row_q <= ROW_W'(GRID_H);
            sub_q <= '0;
        end else begin
            row_q <= row_d;
            sub_q <= sub_d;
        end
    end

    // The last line of a cell row prepares the next row; the line above the grid prepares row 0.
    assign row0_line  = (vCount == 10'(Y0 - 1));
    assign start_line = row0_line || ((row_d < ROW_W'(GRID_H)) && (sub_d == SUB_W'(CELL - 1)));
    assign scan_start = (hCount == 10'(SCAN_H)) && start_line;
    assign tgt_next   = row0_line ? '0 : (row_d + ROW_W'(1));

    // ------------------------------------------------------------------------------------------
    // Row scan FSM
    // ------------------------------------------------------------------------------------------
    typedef enum logic [2:0] {StIdle, StClear, StSeg, StFood, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [ROW_W-1:0] tgt_q;
    logic             last_seg;
    logic             clr_back, seg_test, food_test, busy;

    assign last_seg = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (scan_start) state_d = StClear;
            StClear: state_d = (len_q == '0) ? StFood : StSeg;
            StSeg:   if (last_seg) state_d = StFood;
            StFood:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clr_back  = (state_q == StClear);
        seg_test  = (state_q == StSeg);
        food_test = (state_q == StFood);
        busy      = (state_q == StClear) || (state_q == StSeg) || (state_q == StFood);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx_q <= '0;
            tgt_q <= '0;
        end else if (state_q == StIdle && scan_start) begin
            idx_q <= '0;
            tgt_q <= tgt_next;
        end else if (seg_test) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // One location tested per Clk: segment list during StSeg, food during StFood.
    logic [LOC_W-1:0]  test_loc;
    logic [31:0]       loc32;
    logic              hit;
    logic [CIDX_W-1:0] hit_col;

    always_comb begin
        test_loc = food_test ? food_q : locs_q[idx_q];
        loc32    = 32'(test_loc);
        hit      = (loc32 < NCELL) && ((loc32 / GRID_W) == 32'(tgt_q));
        hit_col  = CIDX_W'(loc32 % GRID_W);
    end

    // ------------------------------------------------------------------------------------------
    // Double-buffered row bitmap. sel_q picks the front half read by the pixel path.
    // ------------------------------------------------------------------------------------------
    logic [GRID_W-1:0] head_q [2];
    logic [GRID_W-1:0] body_q [2];
    logic [GRID_W-1:0] fbit_q [2];
    logic              sel_q;
    logic              back_sel;

    assign back_sel = ~sel_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                head_q[b] <= '0;
                body_q[b] <= '0;
                fbit_q[b] <= '0;
            end
        end else begin
            if (swap) begin
                sel_q <= ~sel_q;
            end
            if (clr_back) begin
                head_q[back_sel] <= '0;
                body_q[back_sel] <= '0;
                fbit_q[back_sel] <= '0;
            end else if (hit) begin
                if (seg_test && idx_q == '0) begin
                    head_q[back_sel][hit_col] <= 1'b1;
                end else if (seg_test) begin
                    body_q[back_sel][hit_col] <= 1'b1;
                end else if (food_test && food_vld_q) begin
                    fbit_q[back_sel][hit_col] <= 1'b1;
                end
            end
        end
    end

    logic overrun_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            overrun_q <= 1'b0;
        end else if (hCount == 10'(X0) && busy) begin
            overrun_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Pixel path. col_q/csub_q hold the position of the pixel after the current one, so the
    // current pixel's position is available combinationally and rgb lags by exactly one Clk.
    // ------------------------------------------------------------------------------------------
    logic [COL_W-1:0]  col_q, col_d, pix_col;
    logic [SUB_W-1:0]  csub_q, csub_d, pix_csub;
    logic [CIDX_W-1:0] pix_cidx;
    logic [11:0]       bg_d, rgb_d, rgb_q, bg_q;

    always_comb begin
        pix_col  = (hCount == 10'(X0)) ? '0 : col_q;
        pix_csub = (hCount == 10'(X0)) ? '0 : csub_q;
        pix_cidx = CIDX_W'(pix_col);
        col_d    = pix_col;
        csub_d   = pix_csub;
        if (pix_col < COL_W'(GRID_W)) begin
            if (pix_csub == SUB_W'(CELL - 1)) begin
                csub_d = '0;
                col_d  = pix_col + COL_W'(1);
            end else begin
                csub_d = pix_csub + SUB_W'(1);
            end
        end
    end

    always_comb begin
        if (Qi) begin
            bg_d = 12'h000;
        end else if (Ql) begin
            bg_d = 12'hF00;
        end else if (Qw) begin
            bg_d = 12'h0F0;
        end else begin
            bg_d = 12'h000;
        end
    end

    always_comb begin
        rgb_d = 12'h000;
        if (Bright) begin
            if (pix_col >= COL_W'(GRID_W) || row_d >= ROW_W'(GRID_H)) begin
                rgb_d = bg_d;
            end else if (head_q[sel_q][pix_cidx]) begin
                rgb_d = HEAD_RGB;
            end else if (body_q[sel_q][pix_cidx]) begin
                rgb_d = BODY_RGB;
            end else if (fbit_q[sel_q][pix_cidx]) begin
                rgb_d = FOOD_RGB;
            end else begin
                rgb_d = bg_d;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            col_q  <= COL_W'(GRID_W);
            csub_q <= '0;
            rgb_q  <= '0;
            bg_q   <= '0;
        end else begin
            col_q  <= col_d;
            csub_q <= csub_d;
            rgb_q  <= rgb_d;
            bg_q   <= bg_d;
        end
    end

    assign rgb          = rgb_q;
    assign background   = bg_q;
    assign scan_overrun = overrun_q;

endmodule
